// File: rtl/uart_rx.sv
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with internal 16x oversample divider and a
//             valid/ready byte interface with framing-error and overrun flags.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int c_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_CNT_W = $clog2(OVERSAMPLE);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic                 meta_q, rx_s_q;
    logic [c_DIV_W-1:0]   div_q;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 done_q, done_d;
    logic                 ferr_d;
    logic [7:0]           data_q;
    logic                 valid_q, ferr_q, ovr_q;
    logic                 w_os_tick;

    assign w_os_tick = (div_q == c_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            div_q  <= '0;
        end else begin
            meta_q <= rx;
            rx_s_q <= meta_q;
            div_q  <= w_os_tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (w_os_tick) begin
            cnt_d = cnt_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (w_os_tick && !rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                idx_d = '0;
                // A start edge that is high again at mid-bit is treated as noise.
                if (w_os_tick && cnt_q == c_HALF_LAST) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_os_tick && cnt_q == c_FULL_LAST) begin
                    shift_d[idx_q] = rx_s_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_os_tick && cnt_q == c_FULL_LAST) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    // Delivery happens one clk after the stop sample, using the handshake
    // state of that same clk to decide between load and overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= ferr_d;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            if (done_q) begin
                if (!valid_q || rx_ready) begin
                    data_q  <= shift_q;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx against a frame-level byte model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

    localparam int P_CLK  = 1000000;
    localparam int P_BAUD = 10000;
    localparam int P_OS   = 16;
    localparam int BIT    = (P_CLK / (P_BAUD * P_OS)) * P_OS;
    localparam int LIMIT  = 20 * BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLK_FREQ  (P_CLK),
        .BAUD      (P_BAUD),
        .OVERSAMPLE(P_OS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc = 0, fe_cnt = 0, drops = 0, rise_cyc = 0, start_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] acc_q[$];
    logic [7:0] exp_q[$];

    // Reference model: what the consumer side should see, frame by frame.
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ovr;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (rx_valid && rx_ready) acc_q.push_back(rx_data);
        if (prev_valid && !rx_valid) drops <= drops + 1;
        if (!prev_valid && rx_valid) rise_cyc <= cyc;
        prev_valid <= rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_ovr   = 1'b0;
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic m_deliver(input logic [7:0] b, input logic accept_now);
        if (!m_valid) begin
            m_valid = 1'b1;
            m_data  = b;
        end else if (accept_now) begin
            exp_q.push_back(m_data);
            m_data = b;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    task automatic m_accept();
        if (m_valid) begin
            exp_q.push_back(m_data);
            m_valid = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_valid"}, rx_valid, m_valid);
        check({tag, "_data"}, rx_data, m_data);
        check({tag, "_overrun"}, overrun, m_ovr);
    endtask

    task automatic check_accepted();
        check("acc_count", acc_q.size(), exp_q.size());
        while (exp_q.size() > 0 && acc_q.size() > 0) begin
            check("acc_byte", acc_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        acc_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rx = f[i];
            if (i == 0) start_cyc = cyc;
            repeat (BIT - 1) @(negedge clk);
        end
    endtask

    task automatic accept();
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_accept();
        check("valid_after_accept", rx_valid, m_valid);
    endtask

    // Raises rx_ready for the single clk right after the frame's stop sample.
    task automatic ready_at_frame_end();
        int t;
        t = 0;
        while (!busy && t < LIMIT) begin @(negedge clk); t++; end
        while (busy && t < LIMIT) begin @(negedge clk); t++; end
        check("frame_end_seen", (t < LIMIT), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [9:0] f;
        int         fe0, d0, lat, gap;

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_data", rx_data, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // Nominal frame and latency
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        m_deliver(8'hA5, 1'b0);
        lat = rise_cyc - start_cyc;
        check("nominal_latency_in_window",
              (lat >= (19 * BIT) / 2 - BIT / 4) && (lat <= (19 * BIT) / 2 + BIT / 4), 1);
        check_state("nominal");
        check("nominal_ferr", fe_cnt - fe0, 0);
        accept();
        check_accepted();

        // Glitch shorter than half a bit
        fe0 = fe_cnt;
        @(negedge clk); rx = 1'b0;
        repeat (BIT / 3) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_busy", busy, 0);
        check("glitch_valid", rx_valid, 0);
        check("glitch_ferr", fe_cnt - fe0, 0);
        send_frame(8'h3C, 1'b1);
        m_deliver(8'h3C, 1'b0);
        check_state("after_glitch");
        accept();
        check_accepted();

        // Framing error
        fe0 = fe_cnt;
        send_frame(8'h0F, 1'b0);
        check("ferr_busy_while_low", busy, 1);
        @(negedge clk); rx = 1'b1;
        repeat (6) @(negedge clk);
        check("ferr_pulse_count", fe_cnt - fe0, 1);
        check("ferr_busy_after_high", busy, 0);
        check_state("ferr");

        // Random bytes, each accepted before the next frame
        repeat (6) begin
            b   = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, BIT);
            repeat (gap) @(negedge clk);
            send_frame(b, 1'b1);
            m_deliver(b, 1'b0);
            check_state("random");
            accept();
        end
        check_accepted();

        // Load and accept in the same clk
        send_frame(8'h55, 1'b1);
        m_deliver(8'h55, 1'b0);
        check_state("coincide_first");
        d0 = drops;
        fork
            send_frame(8'hAA, 1'b1);
            ready_at_frame_end();
        join
        m_deliver(8'hAA, 1'b1);
        check("coincide_no_drop", drops - d0, 0);
        check_state("coincide_second");
        accept();
        check_accepted();

        // Overrun on back-to-back frames
        send_frame(8'h11, 1'b1);
        m_deliver(8'h11, 1'b0);
        send_frame(8'h22, 1'b1);
        m_deliver(8'h22, 1'b0);
        check_state("overrun");
        @(negedge clk); rx_ready = 1'b1;
        m_accept();
        send_frame(8'h33, 1'b1);
        m_deliver(8'h33, 1'b0);
        m_accept();
        @(negedge clk); rx_ready = 1'b0;
        check_state("overrun_sticky");
        check_accepted();

        // Reset in the middle of data bit 4
        b = 8'($urandom_range(0, 255));
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx = f[i];
            repeat ((i == 5) ? BIT / 2 : BIT - 1) @(negedge clk);
        end
        check("midrst_busy_before", busy, 1);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        check("midrst_data", rx_data, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_ferr", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        repeat (12 * BIT) @(negedge clk);
        check("midrst_quiet_valid", rx_valid, 0);
        send_frame(8'hC3, 1'b1);
        m_deliver(8'hC3, 1'b0);
        check_state("after_midrst");
        accept();
        check_accepted();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
